// File: rtl/input_conditioner.sv
// N-channel conditioner for asynchronous board inputs: 2-flop sync, debounce, edge detect,
// wrapping activation counters and LED pulse-stretchers, all on clk27.
module input_conditioner #(
  parameter int unsigned      N_CH            = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 270000,
  parameter int unsigned      STRETCH_CYCLES  = 16777215,
  parameter int unsigned      CNT_W           = 8,
  parameter logic [N_CH-1:0]  IDLE_LEVEL      = {N_CH{1'b1}},
  parameter logic [N_CH-1:0]  ACTIVE_LOW_MASK = {N_CH{1'b1}}
) (
  input  logic                  clk27,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       async_i,
  input  logic                  evt_cnt_clr_i,
  output logic [N_CH-1:0]       stable_o,
  output logic [N_CH-1:0]       rise_o,
  output logic [N_CH-1:0]       fall_o,
  output logic [N_CH*CNT_W-1:0] evt_cnt_o,
  output logic [N_CH-1:0]       led_o
);

  localparam int unsigned DB_W = ($clog2(DEBOUNCE_CYCLES + 1) > 0) ?
                                 $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned ST_W = ($clog2(STRETCH_CYCLES + 1) > 0) ?
                                 $clog2(STRETCH_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STRETCH_CYCLES);

  logic [N_CH-1:0]            s1_q, s1_d, s2_q, s2_d;
  logic [N_CH-1:0]            stable_q, stable_d;
  logic [N_CH-1:0]            rise_q, rise_d, fall_q, fall_d;
  logic [N_CH-1:0][DB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [N_CH-1:0][CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [N_CH-1:0][ST_W-1:0]  str_cnt_q, str_cnt_d;

  always_comb begin
    s1_d      = async_i;
    s2_d      = s1_q;
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    evt_cnt_d = evt_cnt_q;
    str_cnt_d = str_cnt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DB_MAX) begin
        stable_d[i]  = s2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DB_W'(1);
      end

      // A clear coinciding with a pending activation keeps that activation.
      if (rise_q[i]) begin
        evt_cnt_d[i] = evt_cnt_clr_i ? CNT_W'(1) : evt_cnt_q[i] + CNT_W'(1);
      end else if (evt_cnt_clr_i) begin
        evt_cnt_d[i] = '0;
      end

      if (rise_q[i]) begin
        str_cnt_d[i] = ST_MAX;
      end else if (str_cnt_q[i] != '0) begin
        str_cnt_d[i] = str_cnt_q[i] - ST_W'(1);
      end
    end
    // Edges are judged on the logical (mask-corrected) level of the new stable value.
    rise_d = (stable_d ^ stable_q) &  (stable_d ^ ACTIVE_LOW_MASK);
    fall_d = (stable_d ^ stable_q) & ~(stable_d ^ ACTIVE_LOW_MASK);
  end

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= IDLE_LEVEL;
      s2_q      <= IDLE_LEVEL;
      stable_q  <= IDLE_LEVEL;
      rise_q    <= '0;
      fall_q    <= '0;
      deb_cnt_q <= '0;
      evt_cnt_q <= '0;
      str_cnt_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      deb_cnt_q <= deb_cnt_d;
      evt_cnt_q <= evt_cnt_d;
      str_cnt_q <= str_cnt_d;
    end
  end

  always_comb begin
    led_o = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      led_o[i] = (str_cnt_q[i] != '0);
    end
  end

  assign stable_o  = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign evt_cnt_o = evt_cnt_q;

endmodule
